traffic_phase_sequencer: RTL

//   Consumer end of the Divider tick: counts enable_input ticks and steps the junction

---
 rtl/traffic_phase_sequencer_pkg.sv | 41 ++++
 rtl/traffic_phase_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/traffic_phase_sequencer_pkg.sv
// Shared definitions for the junction phase sequencer: phase encodings,
// lamp encodings, default phase durations and the fixed phase order.
package traffic_phase_sequencer_pkg;

  // Phase encodings; 3'd6 and 3'd7 are illegal and recover to MAIN_G.
  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    RED_1  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    RED_2  = 3'd5
  } phase_t;

  // Lamp encodings, {red,yellow,green}.
  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // Default durations in ticks.
  localparam int DEF_CNT_WIDTH      = 6;
  localparam int DEF_MAIN_GREEN_MIN = 10;
  localparam int DEF_MAIN_GREEN_MAX = 30;
  localparam int DEF_SIDE_GREEN     = 8;
  localparam int DEF_YELLOW         = 3;
  localparam int DEF_ALL_RED        = 1;

  // Fixed cycle order; anything unexpected goes back to the resting phase.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      MAIN_G:  return MAIN_Y;
      MAIN_Y:  return RED_1;
      RED_1:   return SIDE_G;
      SIDE_G:  return SIDE_Y;
      SIDE_Y:  return RED_2;
      RED_2:   return MAIN_G;
      default: return MAIN_G;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_sequencer.sv
// Junction phase sequencer. Counts divider ticks inside the current phase and
// steps MAIN_G -> MAIN_Y -> RED_1 -> SIDE_G -> SIDE_Y -> RED_2 -> MAIN_G.
// Main road rests green; the side road is served on a latched request once the
// main-green minimum has elapsed, or unconditionally at the main-green maximum.
module traffic_phase_sequencer
  import traffic_phase_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int MAIN_GREEN_MIN = DEF_MAIN_GREEN_MIN,
  parameter int MAIN_GREEN_MAX = DEF_MAIN_GREEN_MAX,
  parameter int SIDE_GREEN     = DEF_SIDE_GREEN,
  parameter int YELLOW         = DEF_YELLOW,
  parameter int ALL_RED        = DEF_ALL_RED
) (
  input  logic       clk,
  input  logic       sequencer_reset,
  input  logic       enable_input,
  input  logic       side_request,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [2:0] phase,
  output logic       phase_change
);

  // Count value on the last tick of each phase (a phase lasts DUR ticks).
  localparam logic [CNT_WIDTH-1:0] L_MIN_LAST       = CNT_WIDTH'(MAIN_GREEN_MIN - 1);
  localparam logic [CNT_WIDTH-1:0] L_MAX_LAST       = CNT_WIDTH'(MAIN_GREEN_MAX - 1);
  localparam logic [CNT_WIDTH-1:0] L_SIDE_GRN_LAST  = CNT_WIDTH'(SIDE_GREEN - 1);
  localparam logic [CNT_WIDTH-1:0] L_YELLOW_LAST    = CNT_WIDTH'(YELLOW - 1);
  localparam logic [CNT_WIDTH-1:0] L_ALL_RED_LAST   = CNT_WIDTH'(ALL_RED - 1);

  phase_t                 r_state;
  phase_t                 w_state_next;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [CNT_WIDTH-1:0]   w_count_next;
  logic                   r_req;
  logic                   w_req_next;
  logic                   r_phase_change;
  logic                   w_advance;
  logic [CNT_WIDTH-1:0]   w_dur_last;

  // Last in-phase count for the fixed-length phases.
  always_comb begin
    w_dur_last = L_MAX_LAST;
    case (r_state)
      MAIN_Y, SIDE_Y: w_dur_last = L_YELLOW_LAST;
      RED_1, RED_2:   w_dur_last = L_ALL_RED_LAST;
      SIDE_G:         w_dur_last = L_SIDE_GRN_LAST;
      default:        w_dur_last = L_MAX_LAST;
    endcase
  end

  // Next phase, in-phase counter and request latch. Without a tick everything
  // holds except that a new request may still be latched.
  always_comb begin
    w_advance    = 1'b0;
    w_state_next = r_state;
    w_count_next = r_count;
    w_req_next   = r_req | side_request;

    case (r_state)
      MAIN_G:  w_advance = enable_input &&
                           (((r_count >= L_MIN_LAST) && r_req) || (r_count == L_MAX_LAST));
      MAIN_Y, RED_1, SIDE_G, SIDE_Y, RED_2:
               w_advance = enable_input && (r_count == w_dur_last);
      default: w_advance = 1'b1;  // illegal encoding: recover immediately
    endcase

    if (w_advance) begin
      w_state_next = next_phase(r_state);
      w_count_next = '0;
    end else if (enable_input) begin
      w_count_next = r_count + 1'b1;
    end

    // Entering side green absorbs the request, even one arriving on that edge.
    if (w_advance && (w_state_next == SIDE_G)) begin
      w_req_next = 1'b0;
    end
  end

  // State, counter, latch and change pulse registers.
  always_ff @(posedge clk) begin
    if (sequencer_reset) begin
      r_state        <= MAIN_G;
      r_count        <= '0;
      r_req          <= 1'b0;
      r_phase_change <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_count        <= w_count_next;
      r_req          <= w_req_next;
      r_phase_change <= w_advance;
    end
  end

  // Lamp decode straight from the phase register.
  always_comb begin
    main_light = LIGHT_RED;
    side_light = LIGHT_RED;
    case (r_state)
      MAIN_G:  main_light = LIGHT_GREEN;
      MAIN_Y:  main_light = LIGHT_YELLOW;
      SIDE_G:  side_light = LIGHT_GREEN;
      SIDE_Y:  side_light = LIGHT_YELLOW;
      default: begin
        main_light = LIGHT_RED;
        side_light = LIGHT_RED;
      end
    endcase
  end

  assign phase        = r_state;
  assign phase_change = r_phase_change;

endmodule
